alu_result_serializer: RTL

- Downstream of the 32-bit ALU. Accepts one 64-bit ALU result per handshake, plus the opcode that produced it.
- Emits the result as a byte stream to the UART transmitter: an optional header byte, then little-endian result bytes.
- The byte count depends on the opcode: Add/Mul send 4 bytes (low word only); Div sends 8 bytes (quotient, then remainder); Nop sends no data bytes.

---
 rtl/alu_result_serializer_if.sv | 22 ++
 rtl/alu_result_serializer.sv | 103 ++++++++++
 2 files changed

// File: rtl/alu_result_serializer_if.sv
// Handshake bundle between the ALU result producer, the serializer and the UART transmitter.
// The slave modport is the serializer's view. The master modport is the view of the surrounding logic.
interface alu_result_serializer_if;
  logic        valid_i;
  logic [1:0]  opcode_i;
  logic [63:0] result_i;
  logic        ready_o;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        last_o;

  modport slave (
    input  valid_i, opcode_i, result_i, ready_i,
    output ready_o, data_o, valid_o, last_o
  );

  modport master (
    output valid_i, opcode_i, result_i, ready_i,
    input  ready_o, data_o, valid_o, last_o
  );
endinterface

// File: rtl/alu_result_serializer.sv
// Turns one 64-bit ALU result into a byte stream for the UART: an optional header byte,
// then the little-endian result bytes. Nop sends 0 data bytes, Add/Mul send 4, Div sends 8.
module alu_result_serializer #(
  parameter bit header_en_p = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  alu_result_serializer_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] res_q;
  logic [1:0]  op_q;
  logic [3:0]  d_bytes;
  logic        is_last;
  logic        take;

  function automatic logic [3:0] data_bytes(input logic [1:0] op);
    case (op)
      2'd0:    return 4'd0;
      2'd3:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  // ready_o is gated by reset so it reads 0 while reset is held, even before the first edge.
  assign bus.ready_o = (state_q == S_IDLE) && reset_ni;
  assign take        = bus.valid_i && bus.ready_o;
  assign d_bytes     = data_bytes(op_q);
  assign is_last     = ({1'b0, cnt_q} == d_bytes - 4'd1);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the capture registers have no reset. They are datapath and are read only outside Idle.
  always_ff @(posedge clk_i) begin
    if (take) begin
      res_q <= bus.result_i;
      op_q  <= bus.opcode_i;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus.valid_o = 1'b0;
    bus.data_o  = 8'h00;
    bus.last_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          cnt_d = '0;
          if (header_en_p)
            state_d = S_HEADER;
          else if (data_bytes(bus.opcode_i) != 4'd0)
            state_d = S_DATA;
        end
      end

      S_HEADER: begin
        bus.valid_o = 1'b1;
        bus.data_o  = {4'hA, 2'b00, op_q};
        bus.last_o  = (d_bytes == 4'd0);
        if (bus.ready_i)
          state_d = (d_bytes == 4'd0) ? S_IDLE : S_DATA;
      end

      S_DATA: begin
        bus.valid_o = 1'b1;
        bus.data_o  = res_q[{cnt_q, 3'b000} +: 8];
        bus.last_o  = is_last;
        if (bus.ready_i) begin
          if (is_last) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
